// File: rtl/ysyx_22051013_mul_sum_if.sv
// Handshake bundle between the Wallace tree, the final-add stage and EX/WB.
// The slave modport is the adder stage. The master modport is its driver and consumer.
interface ysyx_22051013_mul_sum_if #(
    parameter int W    = 132,
    parameter int XLEN = 64,
    parameter int TAGW = 5
);
    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    re_op1;
    logic [W-1:0]    re_op2;
    logic            op2_1;
    logic            addr_cin;
    logic [2:0]      in_op;
    logic [TAGW-1:0] in_tag;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_res;
    logic [TAGW-1:0] out_tag;

    modport master (
        output in_valid, re_op1, re_op2, op2_1, addr_cin, in_op, in_tag,
        output out_ready,
        input  in_ready, out_valid, out_res, out_tag
    );

    modport slave (
        input  in_valid, re_op1, re_op2, op2_1, addr_cin, in_op, in_tag,
        input  out_ready,
        output in_ready, out_valid, out_res, out_tag
    );
endinterface

// File: rtl/ysyx_22051013_mul_sum.sv
// Final carry-propagate adder of the multiplier. The add is split across two registered stages.
// Ports: clk, rst (sync, active-high), flush, and bus (slave side: tree vectors in, result and tag out).
module ysyx_22051013_mul_sum #(
    parameter int W     = 132,
    parameter int SPLIT = 66,
    parameter int XLEN  = 64,
    parameter int TAGW  = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    ysyx_22051013_mul_sum_if.slave bus
);
    localparam int HW = W - SPLIT;

    logic [W-1:0]    b_vec;
    logic [SPLIT:0]  lo_sum;
    logic            adv_a;
    logic            adv_b;

    logic            va;
    logic [SPLIT-1:0] lo_a;
    logic            ca;
    logic [HW-1:0]   ha;
    logic [HW-1:0]   hb;
    logic [2:0]      op_a;
    logic [TAGW-1:0] tag_a;

    logic            vb;
    logic [XLEN-1:0] res_b;
    logic [TAGW-1:0] tag_b;

    logic [HW-1:0]   hi;
    logic [W-1:0]    prod;
    logic [XLEN-1:0] res_sel;
    logic            unused_bits;

    // The carry vector arrives unshifted; its new LSB comes in separately.
    assign b_vec  = {bus.re_op2[W-2:0], bus.op2_1};
    assign lo_sum = {1'b0, bus.re_op1[SPLIT-1:0]}
                  + {1'b0, b_vec[SPLIT-1:0]}
                  + {{SPLIT{1'b0}}, bus.addr_cin};

    assign adv_b        = !vb || bus.out_ready;
    assign adv_a        = !va || adv_b;
    assign bus.in_ready = adv_a;

    always_ff @(posedge clk) begin
        if (rst) begin
            va    <= 1'b0;
            lo_a  <= '0;
            ca    <= 1'b0;
            ha    <= '0;
            hb    <= '0;
            op_a  <= '0;
            tag_a <= '0;
        end else begin
            if (flush) begin
                va <= 1'b0;
            end else if (adv_a) begin
                va <= bus.in_valid;
            end
            if (!flush && adv_a && bus.in_valid) begin
                lo_a  <= lo_sum[SPLIT-1:0];
                ca    <= lo_sum[SPLIT];
                ha    <= bus.re_op1[W-1:SPLIT];
                hb    <= b_vec[W-1:SPLIT];
                op_a  <= bus.in_op;
                tag_a <= bus.in_tag;
            end
        end
    end

    // The low-half carry enters the high half only here, through ca.
    assign hi   = ha + hb + {{(HW-1){1'b0}}, ca};
    assign prod = {hi, lo_a};

    always_comb begin
        res_sel = prod[XLEN-1:0];
        case (op_a)
            3'd1, 3'd2, 3'd3: res_sel = prod[2*XLEN-1:XLEN];
            3'd4: res_sel = {{(XLEN/2){prod[XLEN/2-1]}}, prod[XLEN/2-1:0]};
            default: res_sel = prod[XLEN-1:0];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vb    <= 1'b0;
            res_b <= '0;
            tag_b <= '0;
        end else begin
            if (flush) begin
                vb <= 1'b0;
            end else if (adv_b) begin
                vb <= va;
            end
            if (!flush && adv_b && va) begin
                res_b <= res_sel;
                tag_b <= tag_a;
            end
        end
    end

    assign bus.out_valid = vb;
    assign bus.out_res   = res_b;
    assign bus.out_tag   = tag_b;

    // The product bits above 2*XLEN and the carry-vector MSB are never selected.
    assign unused_bits = ^{prod[W-1:2*XLEN], bus.re_op2[W-1]};
endmodule

// File: tb/tb_ysyx_22051013_mul_sum.sv
// Scoreboard bench for the multiplier final-add stage.
// The driver books accepted ops into a queue. The monitor checks each output against the queue.
module tb_ysyx_22051013_mul_sum;
    logic clk = 1'b0;
    logic rst;
    logic flush;

    always #5 clk = ~clk;

    ysyx_22051013_mul_sum_if #(.W(132), .XLEN(64), .TAGW(5)) bus ();

    ysyx_22051013_mul_sum dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [63:0] res;
        logic [4:0]  tag;
        int          acc;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    logic acc_flag = 1'b0;
    logic exp_v;
    logic exp_r;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] model(input logic [131:0] a, input logic [131:0] b,
                                          input logic o, input logic c,
                                          input logic [2:0] op);
        logic [131:0] p;
        p = a + ((b << 1) | 132'(o)) + 132'(c);
        case (op)
            3'd1, 3'd2, 3'd3: return p[127:64];
            3'd4: return {{32{p[31]}}, p[31:0]};
            default: return p[63:0];
        endcase
    endfunction

    function automatic logic [131:0] r132();
        logic [131:0] v;
        v = {$urandom(), $urandom(), $urandom(), $urandom(), 4'($urandom_range(15, 0))};
        if ($urandom_range(3, 0) == 0) v[65:0] = '1;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: the queue holds every op accepted and not yet delivered, oldest first.
    always @(negedge clk) begin
        exp_v = (q.size() > 0) && (cyc >= q[0].acc + 1);
        checks++;
        if (bus.out_valid !== exp_v) begin
            errors++;
            $display("FAIL out_valid: got %b expected %b (cyc %0d)", bus.out_valid, exp_v, cyc);
        end
        if (bus.out_valid === 1'b1 && q.size() > 0) begin
            checks++;
            if (bus.out_res !== q[0].res || bus.out_tag !== q[0].tag) begin
                errors++;
                $display("FAIL result: got %h/%0d expected %h/%0d", bus.out_res, bus.out_tag,
                         q[0].res, q[0].tag);
            end
        end
        exp_r = (q.size() < 2) || bus.out_ready;
        checks++;
        if (bus.in_ready !== exp_r) begin
            errors++;
            $display("FAIL in_ready: got %b expected %b (cyc %0d)", bus.in_ready, exp_r, cyc);
        end
        if (bus.out_valid === 1'b1 && bus.out_ready && !flush && !rst && q.size() > 0)
            void'(q.pop_front());
    end

    task automatic book();
        acc_flag = 1'b0;
        if (rst || flush) begin
            q.delete();
        end else if (bus.in_valid && bus.in_ready) begin
            q.push_back('{res: model(bus.re_op1, bus.re_op2, bus.op2_1, bus.addr_cin, bus.in_op),
                          tag: bus.in_tag, acc: cyc + 1});
            acc_flag = 1'b1;
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
        book();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [131:0] a, input logic [131:0] b, input logic o,
                        input logic c, input logic [2:0] op, input logic [4:0] tag);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.re_op1   = a;
        bus.re_op2   = b;
        bus.op2_1    = o;
        bus.addr_cin = c;
        bus.in_op    = op;
        bus.in_tag   = tag;
        do begin
            step();
            n++;
        end while (!acc_flag && n < 50);
        if (!acc_flag) begin
            errors++;
            $display("FAIL accept_timeout: got no accept expected accept within 50 cycles");
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        bus.in_valid = 1'b0;
        while (q.size() > 0 && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst           = 1'b1;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.re_op1    = '0;
        bus.re_op2    = '0;
        bus.op2_1     = 1'b0;
        bus.addr_cin  = 1'b0;
        bus.in_op     = '0;
        bus.in_tag    = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_res", bus.out_res, 64'd0);
        chk("rst_tag", 64'(bus.out_tag), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        rst = 1'b0;

        // Simple MUL with fixed two-stage latency.
        send(132'd15, '0, 1'b0, 1'b0, 3'd0, 5'd7);
        step();
        chk("t1_valid", 64'(bus.out_valid), 64'd1);
        chk("t1_res", bus.out_res, 64'd15);
        chk("t1_tag", 64'(bus.out_tag), 64'd7);
        drain();

        // Carry generated exactly at the split boundary.
        send({66'd0, {66{1'b1}}}, '0, 1'b1, 1'b0, 3'd1, 5'd3);
        step();
        chk("t2_mulh", bus.out_res, 64'd4);
        drain();

        // MULW sign extension versus plain MUL.
        send(132'h8000_0000, '0, 1'b0, 1'b0, 3'd4, 5'd1);
        step();
        chk("t3_mulw", bus.out_res, 64'hFFFF_FFFF_8000_0000);
        drain();
        send(132'h8000_0000, '0, 1'b0, 1'b0, 3'd0, 5'd2);
        step();
        chk("t3_mul", bus.out_res, 64'h0000_0000_8000_0000);
        drain();

        // Back-to-back ops against a consumer stalled for three cycles.
        bus.out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++)
                    send(r132(), r132(), 1'($urandom), 1'($urandom), 3'(i), 5'(10 + i));
            end
            begin
                repeat (4) @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        drain();

        // Flush with both stages full and a new op on the input.
        bus.out_ready = 1'b0;
        send(r132(), r132(), 1'b1, 1'b1, 3'd0, 5'd20);
        send(r132(), r132(), 1'b0, 1'b1, 3'd3, 5'd21);
        bus.in_valid = 1'b1;
        bus.in_tag   = 5'd22;
        flush        = 1'b1;
        step();
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        chk("t5_flush_valid", 64'(bus.out_valid), 64'd0);
        bus.out_ready = 1'b1;
        repeat (4) step();

        // Reset with ops in flight, then a fresh op.
        send(132'd99, 132'd5, 1'b1, 1'b0, 3'd0, 5'd9);
        send(132'd77, 132'd3, 1'b0, 1'b1, 3'd0, 5'd8);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_valid", 64'(bus.out_valid), 64'd0);
        chk("t6_res", bus.out_res, 64'd0);
        chk("t6_tag", 64'(bus.out_tag), 64'd0);
        send(132'd40, 132'd1, 1'b0, 1'b1, 3'd0, 5'd30);
        step();
        chk("t6_new_res", bus.out_res, 64'd43);
        drain();

        // Randomised traffic with backpressure and occasional flushes.
        for (int i = 0; i < 600; i++) begin
            bus.in_valid  = ($urandom_range(9, 0) < 7);
            bus.re_op1    = r132();
            bus.re_op2    = r132();
            bus.op2_1     = 1'($urandom);
            bus.addr_cin  = 1'($urandom);
            bus.in_op     = 3'($urandom_range(7, 0));
            bus.in_tag    = 5'($urandom);
            bus.out_ready = ($urandom_range(9, 0) < 6);
            flush         = ($urandom_range(39, 0) == 0);
            step();
        end
        flush         = 1'b0;
        bus.out_ready = 1'b1;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
